// File: rtl/adrv9009_pkg.sv
// Shared constants, state encoding and fixed-point helpers for the ADRV9009 TX filter chain.
package adrv9009_pkg;

  // THB3 half-band taps (Q15); centre tap and outer pair.
  localparam logic signed [15:0] THB3_H0    = -16'sd1024;
  localparam logic signed [15:0] THB3_H2    = 16'sd9216;
  localparam logic signed [15:0] THB3_HC    = 16'sd16384;
  localparam int                 THB3_SHIFT = 14;

  // Working width of the shared round/saturate helper; wide enough for every TX stage accumulator.
  localparam int RS_ACC_W = 48;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PH_E  = 2'd1,
    PH_O  = 2'd2
  } thb_state_t;

  // Round half-up by 2^(shift-1), arithmetic shift right, then clamp to a signed out_w range.
  function automatic logic signed [RS_ACC_W-1:0] round_sat(
    input logic signed [RS_ACC_W-1:0] acc,
    input int                         shift,
    input int                         out_w
  );
    logic signed [RS_ACC_W-1:0] half;
    logic signed [RS_ACC_W-1:0] r;
    logic signed [RS_ACC_W-1:0] hi;
    logic signed [RS_ACC_W-1:0] lo;
    half = (shift > 0) ? (RS_ACC_W'(1) <<< (shift - 1)) : '0;
    r    = (acc + half) >>> shift;
    hi   = (RS_ACC_W'(1) <<< (out_w - 1)) - RS_ACC_W'(1);
    lo   = ~hi;
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/adrv9009_round_sat.sv
// Combinational round-half-up, shift and saturate; shared by the THB1/THB2/THB3 stages.
module adrv9009_round_sat
  import adrv9009_pkg::*;
#(
  parameter int IN_W  = 34,
  parameter int SHIFT = 14,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  acc,
  output logic signed [OUT_W-1:0] res
);

  logic signed [RS_ACC_W-1:0] wide;

  always_comb begin
    wide = round_sat(RS_ACC_W'(acc), SHIFT, OUT_W);
    res  = wide[OUT_W-1:0];
  end

endmodule

// File: rtl/adrv9009_thb3.sv
// THB3 transmit half-band interpolator: x2 interpolation, 7-tap kernel, valid/ready on both sides.
module adrv9009_thb3
  import adrv9009_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SHIFT  = THB3_SHIFT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int PW = DATA_W + 16;  // product width
  localparam int SW = PW + 2;       // phase-E accumulator width

  logic signed [DATA_W-1:0] x1, x2, x3;
  logic signed [PW-1:0]     p_e0, p_e1, p_e2, p_e3, p_o;
  logic                     p1_valid;
  logic signed [SW-1:0]     sum_e;
  logic signed [DATA_W-1:0] e_rs, o_rs;
  logic signed [DATA_W-1:0] y_e, y_o;
  thb_state_t               state, state_nxt;
  logic                     pair_free, p1_load, in_fire;

  always_comb begin
    pair_free = (state == EMPTY) || (state == PH_O && out_ready);
    p1_load   = p1_valid && pair_free;
    in_ready  = !p1_valid || pair_free;
    in_fire   = in_valid && in_ready;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values;
  // here that is what lets P1 read the old x1/x2/x3 while the history shifts in the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x1       <= '0;
      x2       <= '0;
      x3       <= '0;
      p_e0     <= '0;
      p_e1     <= '0;
      p_e2     <= '0;
      p_e3     <= '0;
      p_o      <= '0;
      p1_valid <= 1'b0;
    end else begin
      if (in_fire) begin
        x1   <= in_data;
        x2   <= x1;
        x3   <= x2;
        p_e0 <= PW'(in_data) * PW'(THB3_H0);
        p_e1 <= PW'(x1) * PW'(THB3_H2);
        p_e2 <= PW'(x2) * PW'(THB3_H2);
        p_e3 <= PW'(x3) * PW'(THB3_H0);
        p_o  <= PW'(x1) * PW'(THB3_HC);
      end
      // A same-cycle input refills P1 as it empties, so in_fire wins over p1_load.
      if (in_fire)      p1_valid <= 1'b1;
      else if (p1_load) p1_valid <= 1'b0;
    end
  end

  assign sum_e = SW'(p_e0) + SW'(p_e1) + SW'(p_e2) + SW'(p_e3);

  adrv9009_round_sat #(.IN_W(SW), .SHIFT(SHIFT), .OUT_W(DATA_W)) u_rs_e (
    .acc (sum_e),
    .res (e_rs)
  );

  adrv9009_round_sat #(.IN_W(PW), .SHIFT(SHIFT), .OUT_W(DATA_W)) u_rs_o (
    .acc (p_o),
    .res (o_rs)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_e   <= '0;
      y_o   <= '0;
      state <= EMPTY;
    end else begin
      if (p1_load) begin
        y_e <= e_rs;
        y_o <= o_rs;
      end
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    out_data  = '0;
    unique case (state)
      EMPTY: begin
        if (p1_load) state_nxt = PH_E;
      end
      PH_E: begin
        out_valid = 1'b1;
        out_data  = y_e;
        if (out_ready) state_nxt = PH_O;
      end
      PH_O: begin
        out_valid = 1'b1;
        out_data  = y_o;
        if (p1_load)        state_nxt = PH_E;
        else if (out_ready) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

endmodule

// File: tb/tb_adrv9009_thb3.sv
// Self-checking bench for adrv9009_thb3: directed vectors, backpressure, random handshakes, mid-stream reset.
module tb_adrv9009_thb3;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;

  int n_checks = 0;
  int n_errors = 0;
  int stim[$];
  int exp_q[$];
  int got[$];

  adrv9009_thb3 dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int rnd_sat(input longint acc);
    longint r;
    r = (acc + 64'sd8192) >>> 14;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  // Reference filter: direct-form evaluation of both polyphase outputs per input.
  task automatic build_exp();
    longint h1 = 0, h2 = 0, h3 = 0, x;
    exp_q.delete();
    foreach (stim[i]) begin
      x = longint'(stim[i]);
      exp_q.push_back(rnd_sat(-1024 * x + 9216 * h1 + 9216 * h2 - 1024 * h3));
      exp_q.push_back(rnd_sat(16384 * h1));
      h3 = h2;
      h2 = h1;
      h1 = x;
    end
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // mode 0: always valid/ready; 1: random in_valid/out_ready; 2: out_ready low for cycles 5..10
  task automatic run_stream(input int mode, input int budget);
    int sent = 0;
    int cyc = 0;
    int held = 0;
    bit saw_low = 1'b0;
    got.delete();
    while ((sent < stim.size() || got.size() < 2 * stim.size()) && cyc < budget) begin
      @(posedge clk);
      #1;
      in_valid  = (sent < stim.size()) && (mode != 1 || $urandom_range(0, 2) != 0);
      in_data   = in_valid ? 16'(stim[sent]) : 16'sd0;
      out_ready = (mode == 1) ? ($urandom_range(0, 1) == 1) : !(mode == 2 && cyc >= 5 && cyc <= 10);
      @(negedge clk);
      if (mode == 2 && cyc == 5) begin
        check("bp_out_valid", int'(out_valid), 1);
        held = int'(out_data);
      end
      if (mode == 2 && cyc > 5 && cyc <= 10) begin
        check($sformatf("bp_hold_c%0d", cyc), int'(out_data), held);
        if (!in_ready) saw_low = 1'b1;
      end
      if (out_valid && out_ready) got.push_back(int'(out_data));
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    check("within_budget", int'(cyc < budget), 1);
    if (mode == 2) check("bp_in_ready_dropped", int'(saw_low), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, got.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < got.size()) check($sformatf("%s[%0d]", tag, i), got[i], exp_q[i]);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_in_ready", int'(in_ready), 1);
    apply_reset();

    // DC 1000: settles to 1000 once the history is full
    stim  = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
    exp_q = '{-62, 0, 500, 1000, 1063, 1000, 1000, 1000,
              1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
    run_stream(0, 200);
    compare_stream("dc");

    // Impulse reproduces the kernel taps
    apply_reset();
    stim  = '{16384, 0, 0, 0, 0, 0, 0, 0};
    exp_q = '{-1024, 0, 9216, 16384, 9216, 0, -1024, 0,
              0, 0, 0, 0, 0, 0, 0, 0};
    run_stream(0, 200);
    compare_stream("imp");

    // Full-scale: 4th phase-E output (40959 unsaturated) clamps to 32767
    apply_reset();
    stim  = '{-32768, 32767, 32767, -32768};
    exp_q = '{2048, 0, -20480, -32768, -2048, 32767, 32767, 32767};
    run_stream(0, 200);
    compare_stream("sat");

    // Backpressure against the reference model
    apply_reset();
    stim.delete();
    for (int i = 0; i < 12; i++) stim.push_back(i * 1500 - 8000);
    build_exp();
    run_stream(2, 300);
    compare_stream("bp");

    // Random handshakes with random and extreme samples
    apply_reset();
    stim.delete();
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       stim.push_back(-32768);
        1:       stim.push_back(32767);
        default: stim.push_back(int'($urandom_range(0, 65535)) - 32768);
      endcase
    end
    build_exp();
    run_stream(1, 1000);
    compare_stream("rnd");

    // Asynchronous reset between edges while data is in flight
    apply_reset();
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_data   = 16'sd3000;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    check("pre_reset_out_valid", int'(out_valid), 1);
    reset = 1'b1;
    #1;
    check("async_rst_out_valid", int'(out_valid), 0);
    check("async_rst_out_data", int'(out_data), 0);
    check("async_rst_in_ready", int'(in_ready), 1);
    in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    stim  = '{16384, 0, 0, 0, 0, 0, 0, 0};
    exp_q = '{-1024, 0, 9216, 16384, 9216, 0, -1024, 0,
              0, 0, 0, 0, 0, 0, 0, 0};
    run_stream(0, 200);
    compare_stream("imp_after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
